// File: rtl/fa_serial_pkg.sv
// ---------------------------------------------------------------------------
// fa_serial_pkg
//
// Purpose : Shared definitions for the bit-serial full-adder arbiter
//           (fa_serial_arb) and its testbench.
//
// Contents:
//   W_DEFAULT - default operand width in bits
//   N_REQ     - number of requesters sharing the adder (fixed at 2)
//   state_e   - controller state encoding (IDLE, RUN, DONE)
//   rr_pick   - round-robin grant selection between the two requesters
// ---------------------------------------------------------------------------
package fa_serial_pkg;

  localparam int W_DEFAULT = 8;
  localparam int N_REQ     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns the index of the requester to grant. A lone requester always
  // wins; on contention the favoured index (the one not served last) wins.
  // Only meaningful when at least one request bit is set.
  function automatic logic rr_pick(input logic [N_REQ-1:0] req_v,
                                   input logic             favour);
    logic pick;
    if (req_v == 2'b11) pick = favour;
    else                pick = req_v[1];
    return pick;
  endfunction

endpackage : fa_serial_pkg

// File: rtl/fa_cell.sv
// ---------------------------------------------------------------------------
// fa_cell
//
// Purpose : One-bit combinational full adder. The arbiter instantiates
//           exactly one of these and walks it across the operand bits.
//
// Ports   :
//   a, b  in  1  operand bits
//   ci    in  1  carry in
//   s     out 1  sum bit
//   co    out 1  carry out
// ---------------------------------------------------------------------------
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ ci;
  // Generate when both operand bits are set, propagate an incoming carry
  // when exactly one of them is.
  assign co       = (a & b) | (ci & half_sum);

endmodule : fa_cell

// File: rtl/fa_serial_arb.sv
// ---------------------------------------------------------------------------
// fa_serial_arb
//
// Purpose : Two requesters share a single full-adder cell. A granted
//           request has its operands captured, then the sum is produced
//           one bit per cycle, LSB first. The W-bit result and final carry
//           are published for one cycle with done, W+1 cycles after ack.
//
// Parameter:
//   W        operand width in bits, 2..32 (default fa_serial_pkg::W_DEFAULT)
//
// Ports    :
//   clk      in  1  clock, rising edge
//   rst      in  1  asynchronous active-high reset
//   req      in  2  per-requester request, held until the matching ack bit
//   a0, b0   in  W  requester-0 operands
//   a1, b1   in  W  requester-1 operands
//   cin      in  2  per-requester carry in (bit i belongs to requester i)
//   ack      out 2  one-hot grant pulse; operands captured on that edge
//   busy     out 1  high from the cycle after ack through the done cycle
//   done     out 1  one-cycle result-valid pulse
//   done_id  out 1  requester that owns the current result
//   sum      out W  result (modulo 2^W); holds its last value outside done
//   cout     out 1  carry out of bit W-1
//   ovf      out 1  carry into bit W-1 XOR cout; present only when the
//                   macro FA_SERIAL_OVF_EN is defined
// ---------------------------------------------------------------------------
module fa_serial_arb
  import fa_serial_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [1:0]   cin,
  output logic [1:0]   ack,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] sum,
`ifdef FA_SERIAL_OVF_EN
  output logic         ovf,
`endif
  output logic         cout
);

  localparam int             CW     = $clog2(W);
  localparam logic [CW-1:0]  K_LAST = CW'(W - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [CW-1:0]  k_q,     k_d;      // bit currently fed to the adder cell
  logic [W-1:0]   a_q,     a_d;      // captured operands
  logic [W-1:0]   b_q,     b_d;
  logic           carry_q, carry_d;  // ripple carry between serial steps
  logic           id_q,    id_d;     // owner of the operation in flight
  logic           prio_q,  prio_d;   // requester favoured on contention
  logic [W-1:0]   res_q,   res_d;    // partial sum being assembled
  logic [W-1:0]   sum_q,   sum_d;    // last completed result
  logic           cout_q,  cout_d;
`ifdef FA_SERIAL_OVF_EN
  logic           ovf_q,   ovf_d;
`endif

  logic [1:0]     ack_grant;
  logic           grant_id;

  // -------------------------------------------------------------------------
  // Shared full-adder cell, fed with bit k of the captured operands
  // -------------------------------------------------------------------------
  logic bit_a, bit_b, fa_s, fa_co;

  assign bit_a = a_q[k_q];
  assign bit_b = b_q[k_q];

  fa_cell u_fa (
    .a  (bit_a),
    .b  (bit_b),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // through the case statement leaves one unassigned (which would infer
    // a latch).
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    id_d      = id_q;
    prio_d    = prio_q;
    res_d     = res_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef FA_SERIAL_OVF_EN
    ovf_d     = ovf_q;
`endif
    ack_grant = 2'b00;
    grant_id  = rr_pick(req, prio_q);

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          ack_grant = grant_id ? 2'b10 : 2'b01;
          a_d       = grant_id ? a1 : a0;
          b_d       = grant_id ? b1 : b0;
          carry_d   = cin[grant_id];
          id_d      = grant_id;
          prio_d    = ~grant_id;   // the other requester wins next tie
          k_d       = '0;
          state_d   = RUN;
        end
      end

      RUN: begin
        res_d[k_q] = fa_s;
        carry_d    = fa_co;
        if (k_q == K_LAST) begin
          // Publish the whole word at once so sum never shows a
          // half-built value.
          sum_d   = res_d;
          cout_d  = fa_co;
`ifdef FA_SERIAL_OVF_EN
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = DONE;
        end else begin
          k_d = k_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef FA_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // values from before this edge, independent of statement order.
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef FA_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // ack is decoded from IDLE and req; masking with rst keeps it low while
  // reset is held even if requests are already asserted.
  assign ack     = rst ? 2'b00 : ack_grant;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = id_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
`ifdef FA_SERIAL_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule : fa_serial_arb

// File: doc/fa_serial_arb.md
FA_SERIAL_ARB -- requirements
Module: fa_serial_arb

Interface
REQ-001 Parameter W, default 8, operand width in bits (legal 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  2  per-requester add request, held until matching ack bit seen.
REQ-005 a0, b0  input  W  requester-0 operands; a1, b1  input  W  requester-1 operands.
REQ-006 cin  input  2  per-requester carry-in, bit i belongs to requester i.
REQ-007 ack  output  2  one-hot one-cycle pulse; operands of granted requester captured that edge.
REQ-008 busy  output  1  high from cycle after ack through done cycle inclusive.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 done_id  output  1  requester index owning current result.
REQ-011 sum  output  W  result; cout  output  1  final carry.

Function
REQ-012 Block shall share one combinational full-adder cell between two requesters, computing W-bit sums bit-serially, LSB first.
REQ-013 FSM states: IDLE, RUN, DONE; shall be encoded as a package enum.
REQ-014 IDLE: if any req bit high, grant per REQ-018, pulse ack, latch a, b, cin, clear bit counter, go RUN; else stay IDLE, ack=0.
REQ-015 RUN: each cycle shall feed bit k of latched a/b plus carry register to the full-adder cell, write sum bit k, update carry register, increment k; after k=W-1 go DONE.
REQ-016 DONE: done=1, done_id, sum, cout stable for exactly that cycle; next state IDLE.
REQ-017 Latency: done shall assert exactly W+1 cycles after the ack cycle (W=8: ack at cycle 0, done at cycle 9).
REQ-018 Arbitration round-robin: single requester always granted; simultaneous requests grant the index not served last; pointer updates only on ack.
REQ-019 Requests during RUN/DONE shall be ignored until IDLE; no request is lost while req held.
REQ-020 Back-to-back: IDLE after DONE shall grant in that same IDLE cycle; minimum spacing between acks is W+2 cycles.
REQ-021 Arithmetic modulo 2^W; cout is the carry out of bit W-1; operand changes after ack shall not affect result.
REQ-022 sum/cout shall hold last result outside DONE; only done qualifies validity.

Reset
REQ-023 rst high shall force IDLE asynchronously, including mid-RUN, aborting the operation with no done pulse.
REQ-024 Reset values: ack=0, busy=0, done=0, done_id=0, sum=0, cout=0, carry register=0, counter=0, RR pointer favouring requester 0.

Configuration
REQ-025 Macro FA_SERIAL_OVF_EN: when defined, add output ovf (1 bit) = carry into bit W-1 XOR cout, valid with done, reset 0.
REQ-026 Without FA_SERIAL_OVF_EN port ovf and its logic shall not exist; all other behaviour identical.

Structure
REQ-027 Shared package fa_serial_pkg shall hold state enum, default W constant, requester count constant (2).
REQ-028 Full-adder cell shall be sub-module fa_cell (a, b, ci -> s, co), purely combinational, instantiated once.
REQ-029 Counter width clog2(W); no other arithmetic on operands besides fa_cell.

Verification
REQ-030 Single req0, a0=0x35, b0=0x4A, cin0=0 -> ack=01, done 9 cycles later, sum=0x7F, cout=0, done_id=0.
REQ-031 Carry chain: req1, a1=0xFF, b1=0x01, cin1=0 -> sum=0x00, cout=1, done_id=1; with FA_SERIAL_OVF_EN, a=0x7F b=0x01 -> ovf=1.
REQ-032 Contention: req=11 held continuously from reset -> ack sequence 01,10,01,10, acks spaced 10 cycles (W=8).
REQ-033 Operand change: after ack, drive a0=0x00 during RUN -> result from captured operands unchanged.
REQ-034 Reset mid-op: assert rst at RUN cycle 4 -> busy=0 immediately, no done, next req0 granted with correct sum.
REQ-035 cin: a0=0x00, b0=0x00, cin0=1 -> sum=0x01, cout=0.
